// File: rtl/div_pkg.sv
// Shared types and codes for the Newton-Raphson division sequencer.
package div_pkg;

  // Sequencer states; encodings are fixed so they can be read off a waveform.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StLut    = 4'd1,
    StNMul1  = 4'd2,
    StNWait1 = 4'd3,
    StNA     = 4'd4,
    StNMul2  = 4'd5,
    StNWait2 = 4'd6,
    StNX     = 4'd7,
    StQMul1  = 4'd8,
    StQWait1 = 4'd9,
    StQE     = 4'd10,
    StQMul2  = 4'd11,
    StQWait2 = 4'd12,
    StQEb    = 4'd13,
    StResult = 4'd14
  } div_state_e;

  // Multiplier operand A select codes.
  localparam logic [1:0] SEL_X  = 2'b00;  // x
  localparam logic [1:0] SEL_A  = 2'b01;  // A
  localparam logic [1:0] SEL_FA = 2'b10;  // {fa, 5'b0}
  localparam logic [1:0] SEL_E  = 2'b11;  // {E, 3'b0}

  // Multiplier operand B select codes.
  localparam logic SEL_FB = 1'b0;  // {fb, 5'b0}
  localparam logic SEL_XB = 1'b1;  // x

  // Newton iteration counts.
  localparam logic [1:0] ITER_SP = 2'd2;
  localparam logic [1:0] ITER_DP = 2'd3;

endpackage

// File: rtl/mul_wait_cnt.sv
// Loadable down-counter timing the multiplier latency; shared by every wait state.
module mul_wait_cnt #(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,  // issue cycle: arm with MUL_LAT-1
  input  logic dec_i,   // wait cycle: count down
  output logic last_o   // this decrement brings the count to zero
);

  localparam int unsigned W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [W-1:0] LoadVal = W'(MUL_LAT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load on issue, saturating decrement while waiting.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/div_seq_ctrl.sv
// Moore sequencer for the Newton-Raphson divider: seed lookup, Newton iterations,
// quotient and remainder multiplies, result load. Drives selects and load strobes only.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int unsigned MUL_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       db,
  output logic       busy,
  output logic       done,
  output logic       mul_own,
  output logic [1:0] sel_a,
  output logic       sel_b,
  output logic       ld_x_lut,
  output logic       ld_a,
  output logic       ld_x,
  output logic       ld_d,
  output logic       ld_e,
  output logic       ld_eb,
  output logic       ld_fq,
  output logic       e_db_mask
);

  localparam bit NoWait = (MUL_LAT == 1);

  div_state_e state_q, state_d;
  logic       db_q, db_d;
  logic [1:0] itc_q, itc_d;
  logic       wc_load, wc_dec, wc_last;

  mul_wait_cnt #(
    .MUL_LAT(MUL_LAT)
  ) u_wait_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .load_i(wc_load),
    .dec_i (wc_dec),
    .last_o(wc_last)
  );

  // Next-state logic and Moore output decode from the state register.
  always_comb begin
    state_d  = state_q;
    db_d     = db_q;
    itc_d    = itc_q;
    wc_load  = 1'b0;
    wc_dec   = 1'b0;
    done     = 1'b0;
    sel_a    = SEL_X;
    sel_b    = SEL_FB;
    ld_x_lut = 1'b0;
    ld_a     = 1'b0;
    ld_x     = 1'b0;
    ld_d     = 1'b0;
    ld_e     = 1'b0;
    ld_eb    = 1'b0;
    ld_fq    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLut;
          db_d    = db;
        end
      end
      StLut: begin
        ld_x_lut = 1'b1;
        itc_d    = db_q ? ITER_DP : ITER_SP;
        state_d  = StNMul1;
      end
      // Newton step 1: x * fb, captured into A as the complement.
      StNMul1: begin
        wc_load = 1'b1;
        state_d = NoWait ? StNA : StNWait1;
      end
      StNWait1: begin
        wc_dec = 1'b1;
        if (wc_last) state_d = StNA;
      end
      StNA: begin
        ld_a    = 1'b1;
        state_d = StNMul2;
      end
      // Newton step 2: A * x, captured into x.
      StNMul2: begin
        sel_a   = SEL_A;
        sel_b   = SEL_XB;
        wc_load = 1'b1;
        state_d = NoWait ? StNX : StNWait2;
      end
      StNWait2: begin
        sel_a  = SEL_A;
        sel_b  = SEL_XB;
        wc_dec = 1'b1;
        if (wc_last) state_d = StNX;
      end
      StNX: begin
        sel_a   = SEL_A;
        sel_b   = SEL_XB;
        ld_x    = 1'b1;
        itc_d   = itc_q - 2'd1;
        state_d = (itc_q == 2'd1) ? StQMul1 : StNMul1;
      end
      // Quotient multiply: fa * x.
      StQMul1: begin
        sel_a   = SEL_FA;
        sel_b   = SEL_XB;
        wc_load = 1'b1;
        state_d = NoWait ? StQE : StQWait1;
      end
      StQWait1: begin
        sel_a  = SEL_FA;
        sel_b  = SEL_XB;
        wc_dec = 1'b1;
        if (wc_last) state_d = StQE;
      end
      StQE: begin
        sel_a   = SEL_FA;
        sel_b   = SEL_XB;
        ld_e    = 1'b1;
        ld_d    = 1'b1;
        state_d = StQMul2;
      end
      // Remainder multiply: E * fb.
      StQMul2: begin
        sel_a   = SEL_E;
        sel_b   = SEL_FB;
        wc_load = 1'b1;
        state_d = NoWait ? StQEb : StQWait2;
      end
      StQWait2: begin
        sel_a  = SEL_E;
        sel_b  = SEL_FB;
        wc_dec = 1'b1;
        if (wc_last) state_d = StQEb;
      end
      StQEb: begin
        sel_a   = SEL_E;
        sel_b   = SEL_FB;
        ld_eb   = 1'b1;
        state_d = StResult;
      end
      StResult: begin
        ld_fq   = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Divider owns the multiplier from seed lookup through the last capture.
  assign busy      = (state_q != StIdle);
  assign mul_own   = (state_q != StIdle) && (state_q != StResult);
  assign e_db_mask = db_q;

  // State, latched precision and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      db_q    <= 1'b0;
      itc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      itc_q   <= itc_d;
    end
  end

endmodule
